utm_step_engine: RTL and testbench

//   Parametrised, sequential Turing-machine core: programmable transition table

---
 rtl/utm_step_engine_if.sv | 40 ++++
 rtl/utm_step_engine.sv | 117 +++++++++++
 tb/tb_utm_step_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/utm_step_engine_if.sv
// rtl/utm_step_engine_if.sv - host-side bus bundle for the Turing-machine step engine
interface utm_step_engine_if #(
    parameter int STATE_W    = 3,
    parameter int SYM_W      = 3,
    parameter int TAPE_DEPTH = 16,
    parameter int CNT_W      = 16
);
    localparam int HEAD_W = $clog2(TAPE_DEPTH);

    logic                       tbl_we;
    logic [STATE_W+SYM_W-1:0]   tbl_addr;
    logic [STATE_W+SYM_W:0]     tbl_wdata;
    logic                       tape_we;
    logic [HEAD_W-1:0]          tape_addr;
    logic [SYM_W-1:0]           tape_wdata;
    logic [SYM_W-1:0]           tape_rdata;
    logic                       start;
    logic                       resume;
    logic [HEAD_W-1:0]          start_head;
    logic                       step_mode;
    logic [CNT_W-1:0]           step_limit;
    logic                       busy;
    logic                       done;
    logic [1:0]                 halt_reason;
    logic [STATE_W-1:0]         state_out;
    logic [HEAD_W-1:0]          head_out;
    logic [CNT_W-1:0]           step_count;

    modport master (
        output tbl_we, tbl_addr, tbl_wdata, tape_we, tape_addr, tape_wdata,
               start, resume, start_head, step_mode, step_limit,
        input  tape_rdata, busy, done, halt_reason, state_out, head_out, step_count
    );

    modport slave (
        input  tbl_we, tbl_addr, tbl_wdata, tape_we, tape_addr, tape_wdata,
               start, resume, start_head, step_mode, step_limit,
        output tape_rdata, busy, done, halt_reason, state_out, head_out, step_count
    );
endinterface

// File: rtl/utm_step_engine.sv
// rtl/utm_step_engine.sv - table-driven Turing-machine core with tape, head and step counter
module utm_step_engine #(
    parameter int                 STATE_W    = 3,
    parameter int                 SYM_W      = 3,
    parameter int                 TAPE_DEPTH = 16,
    parameter logic [STATE_W-1:0] HALT_STATE = {STATE_W{1'b1}},
    parameter int                 CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    utm_step_engine_if.slave bus
);
    localparam int HEAD_W    = $clog2(TAPE_DEPTH);
    localparam int ADDR_W    = STATE_W + SYM_W;
    localparam int ENT_W     = ADDR_W + 1;
    localparam int TBL_DEPTH = 1 << ADDR_W;
    localparam logic [HEAD_W-1:0] HEAD_MAX = HEAD_W'(TAPE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_DONE} fsm_e;

    fsm_e               fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [HEAD_W-1:0]  head_q;
    logic [CNT_W-1:0]   count_q;
    logic [1:0]         reason_q;
    logic               busy_q;
    logic               done_q;
    logic               step_mode_q;
    logic [ENT_W-1:0]   entry_q;
    logic [ENT_W-1:0]   tbl_q  [TBL_DEPTH];
    logic [SYM_W-1:0]   tape_q [TAPE_DEPTH];

    logic [STATE_W-1:0] e_state;
    logic [SYM_W-1:0]   e_sym;
    logic               e_dir;
    logic               at_edge;
    logic               limit_hit;
    logic [HEAD_W-1:0]  head_d;
    logic [CNT_W-1:0]   count_d;

    always_comb begin
        e_state   = entry_q[ENT_W-1 -: STATE_W];
        e_sym     = entry_q[SYM_W:1];
        e_dir     = entry_q[0];
        at_edge   = e_dir ? (head_q == HEAD_MAX) : (head_q == '0);
        // Off-tape moves leave the head parked on the edge cell.
        head_d    = at_edge ? head_q : (e_dir ? head_q + HEAD_W'(1) : head_q - HEAD_W'(1));
        count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        limit_hit = (bus.step_limit != '0) && (count_d == bus.step_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            head_q      <= '0;
            count_q     <= '0;
            reason_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_mode_q <= 1'b0;
            entry_q     <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
            for (int i = 0; i < TAPE_DEPTH; i++) tape_q[i] <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.tbl_we)  tbl_q[bus.tbl_addr]   <= bus.tbl_wdata;
                    if (bus.tape_we) tape_q[bus.tape_addr] <= bus.tape_wdata;
                    if (bus.start) begin
                        if (!bus.resume) begin
                            state_q <= '0;
                            head_q  <= bus.start_head;
                            count_q <= '0;
                        end
                        reason_q    <= 2'b00;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        step_mode_q <= bus.step_mode;
                        fsm_q       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    entry_q <= tbl_q[{state_q, tape_q[head_q]}];
                    fsm_q   <= ST_EXEC;
                end
                ST_EXEC: begin
                    tape_q[head_q] <= e_sym;
                    state_q        <= e_state;
                    count_q        <= count_d;
                    head_q         <= head_d;
                    if (e_state == HALT_STATE || at_edge || limit_hit || step_mode_q) begin
                        if (e_state == HALT_STATE) reason_q <= 2'b01;
                        else if (at_edge)          reason_q <= 2'b10;
                        else if (limit_hit)        reason_q <= 2'b11;
                        else                       reason_q <= 2'b00;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= ST_DONE;
                    end else begin
                        fsm_q <= ST_FETCH;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tape_rdata  = tape_q[bus.tape_addr];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.halt_reason = reason_q;
    assign bus.state_out   = state_q;
    assign bus.head_out    = head_q;
    assign bus.step_count  = count_q;
endmodule

// File: tb/tb_utm_step_engine.sv
// tb/tb_utm_step_engine.sv - randomized self-checking bench for utm_step_engine
module tb_utm_step_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    int m_tbl [64];
    int m_tape [16];
    int m_state, m_head, m_count;

    utm_step_engine_if #(.STATE_W(3), .SYM_W(3), .TAPE_DEPTH(16), .CNT_W(16)) bus ();

    utm_step_engine #(.STATE_W(3), .SYM_W(3), .TAPE_DEPTH(16), .HALT_STATE(3'd7), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_tbl[i]) m_tbl[i] = 0;
        foreach (m_tape[i]) m_tape[i] = 0;
        m_state = 0; m_head = 0; m_count = 0;
    endtask

    task automatic tbl_write(input int addr, input int data);
        @(negedge clk);
        bus.tbl_we = 1'b1; bus.tbl_addr = 6'(addr); bus.tbl_wdata = 7'(data);
        @(negedge clk);
        bus.tbl_we = 1'b0;
        m_tbl[addr] = data;
    endtask

    task automatic tape_write(input int addr, input int data);
        @(negedge clk);
        bus.tape_we = 1'b1; bus.tape_addr = 4'(addr); bus.tape_wdata = 3'(data);
        @(negedge clk);
        bus.tape_we = 1'b0;
        m_tape[addr] = data;
    endtask

    task automatic check_tape(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.tape_addr = 4'(i);
            #1;
            check_val($sformatf("%s_tape%0d", tag, i), 32'(bus.tape_rdata), 32'(m_tape[i]));
        end
    endtask

    // Reference: apply the machine rules step by step on plain integers.
    task automatic model_run(input bit resume, input int head, input bit smode, input int limit,
                             output int steps, output int reason);
        int e, ns, sym, dir;
        bit off;
        if (!resume) begin m_state = 0; m_head = head; m_count = 0; end
        steps = 0; reason = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            e   = m_tbl[m_state * 8 + m_tape[m_head]];
            ns  = (e >> 4) & 7;
            sym = (e >> 1) & 7;
            dir = e & 1;
            m_tape[m_head] = sym;
            m_state = ns;
            if (m_count != 65535) m_count++;
            steps++;
            off = (dir == 1) ? (m_head == 15) : (m_head == 0);
            if (!off) m_head = (dir == 1) ? m_head + 1 : m_head - 1;
            if (ns == 7)                           begin reason = 1; break; end
            else if (off)                          begin reason = 2; break; end
            else if (limit != 0 && m_count == limit) begin reason = 3; break; end
            else if (smode)                        begin reason = 0; break; end
        end
    endtask

    task automatic run(input string tag, input bit resume, input int head, input bit smode, input int limit);
        int k, reason, n;
        model_run(resume, head, smode, limit, k, reason);
        @(negedge clk);
        bus.start = 1'b1; bus.resume = resume; bus.start_head = 4'(head);
        bus.step_mode = smode; bus.step_limit = 16'(limit);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_val({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_cycles"}, 32'(n), 32'(2 * k));
        check_val({tag, "_done"}, 32'(bus.done), 32'd1);
        check_val({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        check_val({tag, "_state"}, 32'(bus.state_out), 32'(m_state));
        check_val({tag, "_head"}, 32'(bus.head_out), 32'(m_head));
        check_val({tag, "_count"}, 32'(bus.step_count), 32'(m_count));
        check_val({tag, "_reason"}, 32'(bus.halt_reason), 32'(reason));
        check_tape(tag);
    endtask

    task automatic clear_tape();
        for (int i = 0; i < 16; i++) tape_write(i, 0);
    endtask

    initial begin
        int n, lim;
        bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_wdata = 0;
        bus.tape_we = 0; bus.tape_addr = 0; bus.tape_wdata = 0;
        bus.start = 0; bus.resume = 0; bus.start_head = 0;
        bus.step_mode = 0; bus.step_limit = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_done", 32'(bus.done), 0);
        check_val("rst_state", 32'(bus.state_out), 0);
        check_val("rst_head", 32'(bus.head_out), 0);
        check_val("rst_count", 32'(bus.step_count), 0);
        check_tape("rst");

        tbl_write(0, 7'b001_001_1);
        tbl_write(8, 7'b111_001_1);
        run("t2", 0, 3, 0, 0);
        check_val("t2_fixed_state", 32'(bus.state_out), 32'd7);

        clear_tape();
        tbl_write(0, 7'b000_001_0);
        run("t3", 0, 0, 0, 0);

        clear_tape();
        tbl_write(0, 7'b000_000_1);
        run("t4", 0, 0, 0, 5);
        check_val("t4_fixed_head", 32'(bus.head_out), 32'd5);

        clear_tape();
        tbl_write(0, 7'b001_001_1);
        run("t5a", 0, 3, 1, 0);
        run("t5b", 1, 0, 1, 0);

        // Mid-run disruption: busy-time host writes and restarts must be ignored, then reset.
        clear_tape();
        tbl_write(0, 7'b000_000_1);
        @(negedge clk);
        bus.start = 1; bus.resume = 0; bus.start_head = 0; bus.step_mode = 0; bus.step_limit = 5;
        @(negedge clk);
        bus.start = 1; bus.start_head = 4'd9;
        bus.tbl_we = 1; bus.tbl_addr = 0; bus.tbl_wdata = 7'b111_001_1;
        bus.tape_we = 1; bus.tape_addr = 4'd10; bus.tape_wdata = 3'd5;
        @(negedge clk);
        bus.start = 0; bus.tbl_we = 0; bus.tape_we = 0;
        #1;
        check_val("t6_tape_we_ignored", 32'(bus.tape_rdata), 0);
        n = 0;
        while (bus.step_count != 16'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_reach_count3", 32'(bus.step_count), 3);
        check_val("t6_state_mid", 32'(bus.state_out), 0);
        check_val("t6_head_mid", 32'(bus.head_out), 3);
        check_val("t6_busy_mid", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("t6_busy_rst", 32'(bus.busy), 0);
        check_val("t6_done_rst", 32'(bus.done), 0);
        check_val("t6_state_rst", 32'(bus.state_out), 0);
        check_val("t6_head_rst", 32'(bus.head_out), 0);
        check_val("t6_count_rst", 32'(bus.step_count), 0);
        check_val("t6_reason_rst", 32'(bus.halt_reason), 0);
        check_tape("t6rst");
        @(negedge clk);
        rst_n = 1'b1;
        run("t6_cleared_tbl", 0, 0, 0, 0);

        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 64; a++) tbl_write(a, int'($urandom_range(0, 127)));
            for (int w = 0; w < 4; w++) tape_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            lim = m_count + int'($urandom_range(1, 24));
            run($sformatf("rnd%0d", it), ($urandom_range(0, 1) == 1) && it > 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, lim);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
